flash_cmd_arbiter: RTL

- Shares the single low-level QSPI flash controller (LLC_AXI) between two requesters: port 0 is instruction fetch (read-only), port 1 is data (read/program/erase).
- Arbitrates between them, latches the granted command and drives the LLC command lines stable for the whole operation.
- Counts LLC word completions, returns read words to the owner and signals done or timeout error.
- Sits between the CPU-side fetch/data units and LLC_AXI in the SoC top.

---
 rtl/flash_arb_pkg.sv | 36 +++
 rtl/flash_arb_rr.sv | 36 +++
 rtl/flash_cmd_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_arb_pkg.sv
// Shared op codes, FSM states and LLC direction encoding for the flash command arbiter.
package flash_arb_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_PROG  = 2'b01,
        OP_ERASE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;

    localparam logic DIR_IN  = 1'b0;   // flash -> controller
    localparam logic DIR_OUT = 1'b1;   // controller -> flash

    localparam int N_PORTS = 2;

    // Instruction fetch may only read; the reserved code also degrades to a read.
    function automatic op_e decode_op(input logic is_data_port, input logic [1:0] op);
        op_e res;
        res = OP_READ;
        if (is_data_port) begin
            case (op)
                2'b01:   res = OP_PROG;
                2'b10:   res = OP_ERASE;
                default: res = OP_READ;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/flash_arb_rr.sv
// Two-way request picker: fixed priority to port 0, or round-robin on the last accepted grant.
module flash_arb_rr
    import flash_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [N_PORTS-1:0] i_valid,
    input  logic               i_accept,
    output logic [N_PORTS-1:0] o_grant
);

    logic r_last;
    logic w_pick1;

    always_comb begin
        if (FIXED_PRIO) begin
            w_pick1 = i_valid[1] & ~i_valid[0];
        end else begin
            w_pick1 = i_valid[1] & (~i_valid[0] | ~r_last);
        end
    end

    assign o_grant = {w_pick1, i_valid[0] & ~w_pick1};

    // Reset value 1 means port 0 is favoured on the first tie.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last <= 1'b1;
        end else if (i_accept) begin
            r_last <= w_pick1;
        end
    end

endmodule

// File: rtl/flash_cmd_arbiter.sv
// Shares one QSPI low-level controller between instruction fetch (port 0) and data (port 1).
module flash_cmd_arbiter
    import flash_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int TIMEOUT    = 4096,
    parameter int MAX_LEN_W  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_req0_valid,
    output logic                 o_req0_ready,
    input  logic [1:0]           i_req0_op,
    input  logic [23:0]          i_req0_addr,
    input  logic [31:0]          i_req0_wdata,
    input  logic [MAX_LEN_W-1:0] i_req0_len,
    input  logic                 i_req0_quad,
    output logic                 o_req0_rvalid,
    output logic [31:0]          o_req0_rdata,
    output logic                 o_req0_done,
    output logic                 o_req0_err,
    input  logic                 i_req1_valid,
    output logic                 o_req1_ready,
    input  logic [1:0]           i_req1_op,
    input  logic [23:0]          i_req1_addr,
    input  logic [31:0]          i_req1_wdata,
    input  logic [MAX_LEN_W-1:0] i_req1_len,
    input  logic                 i_req1_quad,
    output logic                 o_req1_rvalid,
    output logic [31:0]          o_req1_rdata,
    output logic                 o_req1_done,
    output logic                 o_req1_err,
    output logic                 o_llc_go,
    output logic                 o_llc_write,
    output logic                 o_llc_erase,
    output logic                 o_llc_op_cont,
    output logic                 o_llc_spd,
    output logic                 o_llc_dir,
    output logic [23:0]          o_llc_address,
    output logic [31:0]          o_llc_word,
    input  logic [31:0]          i_llc_word,
    input  logic                 i_llc_valid,
    input  logic                 i_llc_busy
);

    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);

    state_e r_state;
    state_e w_state_next;

    logic [N_PORTS-1:0]   w_valid;
    logic [N_PORTS-1:0]   w_grant;
    logic [N_PORTS-1:0]   w_ready;
    logic                 w_hs;
    logic                 w_sel;
    op_e                  w_op;
    logic [23:0]          w_addr;
    logic [MAX_LEN_W-1:0] w_len;
    logic                 w_quad;
    logic                 w_word_ok;
    logic                 w_last;
    logic                 w_tmo_hit;
    logic                 w_finish;
    logic                 w_unused;

    logic                 r_owner;
    logic                 r_read;
    logic                 r_abort;
    logic [MAX_LEN_W-1:0] r_remaining;
    logic [TMO_W-1:0]     r_tmo;
    logic [N_PORTS-1:0]   r_rvalid;
    logic [N_PORTS-1:0]   r_done;
    logic [N_PORTS-1:0]   r_err;
    logic [31:0]          r_rdata;
    logic                 r_go;
    logic                 r_write;
    logic                 r_erase;
    logic                 r_op_cont;
    logic                 r_spd;
    logic                 r_dir;
    logic [23:0]          r_address;
    logic [31:0]          r_word;

    // Fetch never programs, so its write data has no destination.
    assign w_unused = ^i_req0_wdata;

    assign w_valid = {i_req1_valid, i_req0_valid};

    flash_arb_rr #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_valid  (w_valid),
        .i_accept (w_hs),
        .o_grant  (w_grant)
    );

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_ready
        assign w_ready[gi] = (r_state == ST_IDLE) & w_grant[gi];
    end

    assign w_hs   = |(w_ready & w_valid);
    assign w_sel  = w_grant[1];
    assign w_op   = w_sel ? decode_op(1'b1, i_req1_op) : decode_op(1'b0, i_req0_op);
    assign w_addr = w_sel ? i_req1_addr : i_req0_addr;
    assign w_len  = w_sel ? i_req1_len  : i_req0_len;
    assign w_quad = w_sel ? i_req1_quad : i_req0_quad;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_word_ok    = 1'b0;
        w_last       = 1'b0;
        w_tmo_hit    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // A completing word takes precedence over a timeout in the same cycle.
                if (i_llc_valid) begin
                    w_word_ok = 1'b1;
                    if (r_remaining == '0) begin
                        w_last       = 1'b1;
                        w_state_next = ST_DRAIN;
                    end
                end else if (r_tmo == TMO_MAX) begin
                    w_tmo_hit    = 1'b1;
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!i_llc_busy) begin
                    w_finish     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_owner     <= 1'b0;
            r_read      <= 1'b0;
            r_abort     <= 1'b0;
            r_remaining <= '0;
            r_tmo       <= '0;
            r_rvalid    <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_rdata     <= '0;
            r_go        <= 1'b0;
            r_write     <= 1'b0;
            r_erase     <= 1'b0;
            r_op_cont   <= 1'b0;
            r_spd       <= 1'b0;
            r_dir       <= DIR_IN;
            r_address   <= '0;
            r_word      <= '0;
        end else begin
            r_rvalid <= '0;
            r_done   <= '0;
            r_err    <= '0;

            if (w_hs) begin
                r_owner     <= w_sel;
                r_read      <= (w_op == OP_READ);
                r_abort     <= 1'b0;
                r_remaining <= (w_op == OP_READ) ? w_len : '0;
                r_tmo       <= '0;
                r_go        <= 1'b1;
                r_write     <= (w_op == OP_PROG);
                r_erase     <= (w_op == OP_ERASE);
                r_op_cont   <= (w_op == OP_READ) && (w_len != '0);
                r_spd       <= w_quad;
                r_dir       <= (w_op == OP_READ) ? DIR_IN : DIR_OUT;
                r_address   <= w_addr;
                r_word      <= (w_op == OP_PROG) ? i_req1_wdata : '0;
            end

            if (r_state == ST_RUN) begin
                if (w_word_ok) begin
                    r_tmo <= '0;
                    if (r_read) begin
                        r_rvalid[r_owner] <= 1'b1;
                        r_rdata           <= i_llc_word;
                    end
                    if (!w_last) begin
                        r_remaining <= r_remaining - MAX_LEN_W'(1);
                    end
                end else begin
                    r_tmo <= r_tmo + TMO_W'(1);
                end
                if (w_last || w_tmo_hit) begin
                    r_go      <= 1'b0;
                    r_op_cont <= 1'b0;
                end
                if (w_tmo_hit) begin
                    r_abort <= 1'b1;
                end
            end

            if (w_finish) begin
                r_done[r_owner] <= 1'b1;
                r_err[r_owner]  <= r_abort;
            end
        end
    end

    assign o_req0_ready  = w_ready[0];
    assign o_req1_ready  = w_ready[1];
    assign o_req0_rvalid = r_rvalid[0];
    assign o_req1_rvalid = r_rvalid[1];
    assign o_req0_rdata  = r_rdata;
    assign o_req1_rdata  = r_rdata;
    assign o_req0_done   = r_done[0];
    assign o_req1_done   = r_done[1];
    assign o_req0_err    = r_err[0];
    assign o_req1_err    = r_err[1];
    assign o_llc_go      = r_go;
    assign o_llc_write   = r_write;
    assign o_llc_erase   = r_erase;
    assign o_llc_op_cont = r_op_cont;
    assign o_llc_spd     = r_spd;
    assign o_llc_dir     = r_dir;
    assign o_llc_address = r_address;
    assign o_llc_word    = r_word;

endmodule
